fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, giving the PC/address width.
REQ-002 SHALL have parameter DWIDTH, default 32, giving the instruction width.
REQ-003 SHALL have parameter RESET_PC_VAL, default 32'h4000_0000, giving the PC after reset.
REQ-004 SHALL have parameter PC_STEP, default 4, giving the sequential PC increment.
REQ-005 SHALL have parameter DEPTH, default 4, giving the instruction FIFO depth and credit limit (power of 2, >=2).
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 trap_valid  in  1  force PC to trap_vector (highest priority).
REQ-009 trap_vector  in  AWIDTH  trap target.
REQ-010 redirect_valid  in  1  force PC to redirect_pc (branch/jump).
REQ-011 redirect_pc  in  AWIDTH  redirect target.
REQ-012 imem_req_valid  out  1  fetch request valid.
REQ-013 imem_req_ready  in  1  memory accepts request.
REQ-014 imem_req_addr  out  AWIDTH  fetch address, always equal to pc_out.
REQ-015 imem_resp_valid  in  1  in-order response, 1-cycle pulse, no backpressure.
REQ-016 imem_resp_data  in  DWIDTH  response instruction.
REQ-017 inst_valid  out  1  instruction available to decode.
REQ-018 inst_ready  in  1  decode accepts instruction.
REQ-019 inst_data  out  DWIDTH  FIFO head instruction.
REQ-020 inst_pc  out  AWIDTH  PC of FIFO head instruction.
REQ-021 pc_out  out  AWIDTH  next fetch PC register.

Function
REQ-022 Request handshake = imem_req_valid && imem_req_ready; on handshake pc_out SHALL advance by PC_STEP, wrapping modulo 2^AWIDTH.
REQ-023 imem_req_valid SHALL be 1 iff (inflight + fifo_count) < DEPTH and neither trap_valid nor redirect_valid is high this cycle.
REQ-024 inflight counter SHALL +1 on request handshake, -1 on imem_resp_valid, both in the same cycle = unchanged.
REQ-025 Flush = trap_valid || redirect_valid; next pc_out SHALL be trap_vector if trap_valid, else redirect_pc.
REQ-026 On flush the FIFO SHALL be emptied; a pop in the flush cycle SHALL be ignored.
REQ-027 On flush drop_cnt SHALL load (inflight - imem_resp_valid); a response in the flush cycle SHALL be discarded.
REQ-028 Non-flush response with drop_cnt > 0 SHALL be discarded and decrement drop_cnt.
REQ-029 Non-flush response with drop_cnt == 0 SHALL be pushed with PC = resp_pc; resp_pc then SHALL advance by PC_STEP.
REQ-030 resp_pc SHALL load the flush target on flush.
REQ-031 inst_valid SHALL equal FIFO non-empty; pop on inst_valid && inst_ready.
REQ-032 A pushed instruction SHALL appear on inst_valid the cycle after imem_resp_valid (1-cycle latency).
REQ-033 Push and pop in the same cycle SHALL leave fifo_count unchanged; the credit rule guarantees no overflow.
REQ-034 Pointers SHALL wrap modulo DEPTH.
REQ-035 inst_data/inst_pc SHALL hold stable while inst_valid && !inst_ready.

Reset
REQ-036 While rst_n = 0: pc_out = resp_pc = RESET_PC_VAL; inflight, drop_cnt and fifo_count = 0; imem_req_valid = inst_valid = 0.
REQ-037 After rst_n rises: imem_req_valid = 1 and imem_req_addr = RESET_PC_VAL on the first cycle.
REQ-038 Reset mid-operation SHALL discard all in-flight and buffered state immediately.

Verification
REQ-039 Reset release, imem_req_ready = 1, 1-cycle memory, inst_ready = 1 -> inst_pc sequence 4000_0000, 4000_0004, 4000_0008; pc_out = 4000_0008 two cycles after release.
REQ-040 imem_req_ready = 1, no responses -> exactly DEPTH (4) requests, then imem_req_valid = 0 until a response/pop frees credit.
REQ-041 3 requests in flight, redirect_valid with redirect_pc = 2000_0000 -> next request addr 2000_0000, 3 stale responses dropped, first inst_pc = 2000_0000, then 2000_0004.
REQ-042 trap_valid and redirect_valid same cycle, trap_vector = 0000_0100 -> pc_out = 0000_0100, FIFO empty next cycle.
REQ-043 inst_ready = 0 for 10 cycles -> inst_valid held, inst_data stable, FIFO fills to 4, requests stop, no data lost on resume.
REQ-044 AWIDTH = 16, pc_out = FFFC, PC_STEP = 4 -> next request addr 0000.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module     : fetch_unit
// Description: Credit-limited instruction fetch with PC sequencing, flush
//              handling and an in-order instruction FIFO toward decode.
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
  parameter int                AWIDTH       = 32,
  parameter int                DWIDTH       = 32,
  parameter logic [AWIDTH-1:0] RESET_PC_VAL = AWIDTH'(32'h4000_0000),
  parameter int                PC_STEP      = 4,
  parameter int                DEPTH        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trap_valid,
  input  logic [AWIDTH-1:0] trap_vector,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [AWIDTH-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DWIDTH-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DWIDTH-1:0] inst_data,
  output logic [AWIDTH-1:0] inst_pc,
  output logic [AWIDTH-1:0] pc_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AWIDTH-1:0] STEP = AWIDTH'(PC_STEP);

  logic [CW-1:0]     inflight, drop_cnt, fifo_count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [AWIDTH-1:0] resp_pc;
  logic [DWIDTH-1:0] data_mem [DEPTH];
  logic [AWIDTH-1:0] pc_mem   [DEPTH];

  logic              flush, credit_ok, req_fire, push, pop;
  logic [AWIDTH-1:0] flush_target;

  assign flush        = trap_valid || redirect_valid;
  assign flush_target = trap_valid ? trap_vector : redirect_pc;
  assign credit_ok    = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);
  // Gated by rst_n so the request stays low for the whole reset window.
  assign imem_req_valid = rst_n && credit_ok && !flush;
  assign imem_req_addr  = pc_out;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_resp_valid && !flush && (drop_cnt == '0);
  assign inst_valid     = (fifo_count != '0);
  assign pop            = inst_valid && inst_ready && !flush;
  assign inst_data      = data_mem[rd_ptr];
  assign inst_pc        = pc_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out     <= RESET_PC_VAL;
      resp_pc    <= RESET_PC_VAL;
      inflight   <= '0;
      drop_cnt   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({req_fire, imem_resp_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      if (flush) begin
        pc_out     <= flush_target;
        resp_pc    <= flush_target;
        // Every request still outstanding after this cycle returns stale data.
        drop_cnt   <= inflight - CW'(imem_resp_valid);
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (req_fire)
          pc_out <= pc_out + STEP;
        if (imem_resp_valid && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          resp_pc <= resp_pc + STEP;
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_resp_data;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

endmodule
`default_nettype wire
